// File: rtl/hs32_fetch_pkg.sv
// Shared definitions for the hs32 instruction fetch unit: FSM states, word size, reset PC.
package hs32_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } fetch_state_t;

    localparam int          HS32_WORD_BYTES = 4;
    localparam logic [31:0] HS32_RESET_PC   = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'(HS32_WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/hs32_fetch_fifo.sv
// Synchronous prefetch FIFO for hs32_fetch; clear discards all entries in one cycle.
module hs32_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic [WIDTH-1:0] head
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; contents are only observed while count_reg is non-zero.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_reg] <= din;
    end

    assign head  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_C);
    assign afull = (count_reg == DEPTH_C - 1'b1);

endmodule

// File: rtl/hs32_fetch.sv
// hs32 instruction fetch: PC/FSM, prefetch FIFO, flush redirect.
// Optional HS32_FETCH_BYPASS_EN: empty-FIFO reads reach decode in the same cycle.
module hs32_fetch
    import hs32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = HS32_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] addr,
    output logic        reqm,
    input  logic        rdym,
    input  logic [31:0] dtrm,
    output logic [31:0] instf,
    output logic        rdyd,
    input  logic        reqd,
    input  logic        flush,
    input  logic [31:0] newpc
);
    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;

    logic        fifo_push, fifo_pop;
    logic        fifo_full, fifo_empty, fifo_afull;
    logic [31:0] fifo_head;
    logic        take, byp_used;

    hs32_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush),
        .din   (dtrm),
        .full  (fifo_full),
        .empty (fifo_empty),
        .afull (fifo_afull),
        .head  (fifo_head)
    );

    assign reqm = (state_reg == S_FETCH) && !fifo_full;
    assign addr = pc_reg;
    // A flush drops any read completing in the same cycle.
    assign take = reqm && rdym && !flush;

`ifdef HS32_FETCH_BYPASS_EN
    logic bypass;
    assign bypass   = take && fifo_empty;
    assign byp_used = bypass && reqd;
    assign rdyd     = !fifo_empty || bypass;
    assign instf    = !fifo_empty ? fifo_head : (bypass ? dtrm : 32'h0);
`else
    assign byp_used = 1'b0;
    assign rdyd     = !fifo_empty;
    assign instf    = fifo_empty ? 32'h0 : fifo_head;
`endif

    assign fifo_push = take && !byp_used;
    assign fifo_pop  = reqd && !fifo_empty && !flush;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (flush) begin
            state_next = S_FETCH;
            pc_next    = word_align(newpc);
        end else begin
            case (state_reg)
                S_IDLE:  state_next = S_FETCH;
                S_FETCH: begin
                    if (take) pc_next = pc_reg + 32'(HS32_WORD_BYTES);
                    if (fifo_push && !fifo_pop && fifo_afull) state_next = S_FULL;
                end
                S_FULL:  if (fifo_pop) state_next = S_FETCH;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

endmodule
